// File: rtl/ula_sequencer.sv
// Operand-fetch / write-back sequencer in front of the ula: small register bank,
// one instruction in flight, fixed IDLE -> READ -> EXEC -> WB walk.
module ula_sequencer #(
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_ra,
  input  logic [ADDR_W-1:0] instr_rb,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [WIDTH-1:0]  dbg_data,
  output logic [1:0]        dbg_state,
  output logic [WIDTH-1:0]  opA,
  output logic [WIDTH-1:0]  opB,
  output logic [2:0]        select,
  input  logic [WIDTH-1:0]  saida_ula,
  output logic [WIDTH-1:0]  resultado,
  output logic              flag_zero,
  output logic              result_valid
);

  localparam int NREG = 1 << ADDR_W;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1, S_EXEC = 2'd2, S_WB = 2'd3} state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [ADDR_W-1:0]   ra_q, ra_d, rb_q, rb_d, rd_q, rd_d;
  logic [WIDTH-1:0]    bank_q [NREG];
  logic [WIDTH-1:0]    bank_d [NREG];
  logic [WIDTH-1:0]    opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic [2:0]          sel_q, sel_d;
  logic                zero_q, zero_d;

  // Handshake: an instruction transfers on any rising edge where instr_valid
  // and instr_ready are both high; the source holds it stable until then.
  assign instr_ready  = (state_q == S_IDLE);
  assign result_valid = (state_q == S_WB);
  assign dbg_state    = state_q;
  assign dbg_data     = bank_q[dbg_addr];
  assign opA          = opa_q;
  assign opB          = opb_q;
  assign select       = sel_q;
  assign resultado    = res_q;
  assign flag_zero    = zero_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rd_d    = rd_q;
    bank_d  = bank_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sel_d   = sel_q;
    res_d   = res_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE: begin
        // External loads only land here, so they never collide with write-back.
        if (wr_en) bank_d[wr_addr] = wr_data;
        if (instr_valid) begin
          op_d    = instr_op;
          ra_d    = instr_ra;
          rb_d    = instr_rb;
          rd_d    = instr_rd;
          state_d = S_READ;
        end
      end
      S_READ: begin
        opa_d   = bank_q[ra_q];
        opb_d   = bank_q[rb_q];
        sel_d   = op_q;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d   = saida_ula;
        zero_d  = (saida_ula == '0);
        state_d = S_WB;
      end
      S_WB: begin
        bank_d[rd_q] = res_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rd_q    <= '0;
      for (int i = 0; i < NREG; i++) bank_q[i] <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      sel_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rd_q    <= rd_d;
      for (int i = 0; i < NREG; i++) bank_q[i] <= bank_d[i];
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sel_q   <= sel_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

endmodule
